terrain_probe_sched: RTL and testbench
======================================

# terrain_probe_sched

Schedules collision probes for up to N_ENT entities against the shared single-port terrain bitmap (one 512-bit column word per X address). Once per frame it snapshots each entity's position and probe offsets, issues three column reads per entity in fixed order, and extracts the down, up, left and right contact bits. It publishes all entity flags atomically at scan end. It sits between the entity movement logic and the terrain column RAM, and it is the only reader of that RAM during a scan.

## Interface
- N_ENT, 4, number of entity slots
- COLS, 640, valid column range 0..COLS-1
- ROWS, 480, valid row range 0..ROWS-1
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- frame_start  in  1  single-cycle pulse that starts a scan
- ent_valid  in  N_ENT  per-slot enable
- ent_x, ent_y  in  N_ENT×10  entity anchor position
- ent_d, ent_u, ent_l, ent_r  in  N_ENT×10  probe offsets: down, up, left, right
- mem_rd  out  1  column read strobe
- mem_addr  out  10  column index
- mem_data  in  512  column word, valid the cycle after mem_rd
- dd, uu, ll, rr  out  N_ENT  per-entity contact flags
- busy  out  1  scan in progress
- done  out  1  single-cycle pulse: flags updated

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
  - IDLE: on frame_start, go to SCAN and snapshot all ent_* inputs into registers.
  - SCAN: steps through 3·N_ENT slots, one per cycle. For entity i, slot 3i uses column X, slot 3i+1 uses X−L, slot 3i+2 uses X+R.
  - DRAIN: one cycle to capture the last read word.
  - DONE: one cycle, then back to IDLE.
- Bit extraction from the captured word:
  - slot 3i: dd = word[Y+D], uu = word[Y−U]
  - slot 3i+1: ll = word[Y]
  - slot 3i+2: rr = word[Y]
- Arithmetic: compute all sums and differences at 11 bits.
  - A column address that underflows or is ≥ COLS is out of range.
  - A row index that underflows or is ≥ ROWS is out of range.
- Out-of-range column: mem_rd stays low for that slot. All flags from that slot are forced to 1, because the screen edge is solid.
- Out-of-range row for a single bit: that flag is forced to 1. The other bits from the same word are unaffected.
- Invalid entity (ent_valid[i] = 0 at snapshot): its three slots still take time, but mem_rd stays low and its flags are 0.
- Results go into shadow registers. dd/uu/ll/rr update from the shadow registers only on entry to DONE, so the outputs are never partially updated.
- frame_start while not in IDLE is ignored. It is not queued.
- mem_addr holds its last value when mem_rd is low.

## Timing
- Reset values: dd = uu = ll = rr = 0, busy = 0, done = 0, mem_rd = 0, mem_addr = 0, state IDLE.
- frame_start is high in cycle 0.
- Slot k (0..3·N_ENT−1) drives mem_rd/mem_addr in cycle k+1. Its mem_data is sampled in cycle k+2.
- busy is high in cycles 1 through 3·N_ENT+1.
- done and the new flag values appear in cycle 3·N_ENT+2. With N_ENT = 4, that is cycle 14.
- Fixed latency of 3·N_ENT+2 cycles, independent of validity or range.
- Back-to-back: a frame_start in the done cycle is accepted, because the FSM is already returning to IDLE. A frame_start in any earlier cycle is dropped.
- Reset mid-scan: aborts in the next cycle, clears the flags and shadow registers, returns to IDLE, and emits no done.

## Structure
- Shared package `terrain_pkg`:
  - COLS, ROWS, ROW_BITS = 512
  - the probe slot enum (SLOT_CENTER, SLOT_LEFT, SLOT_RIGHT)
  - the FSM state typedef
- One sub-module, `probe_addr_gen`: combinational. Takes the snapshot entity fields and the slot type. Returns the column address, the column-in-range bit, the row indices, and the row-in-range bits.
- The top level holds the FSM, the slot counter, the one-cycle return pipeline (slot id plus forced-flag mask) and the shadow and output registers.

## Test plan
- Single valid entity 0 at X=100, Y=200, D=U=L=R=10. Column 100 word has bit 210 set, column 90 has bit 200 set, column 110 is all zeros. Expected: done in cycle 14; dd[0]=1, uu[0]=0, ll[0]=1, rr[0]=0; mem_addr sequence 100, 90, 110 in cycles 1–3.
- Edge clamp: entity at X=5, L=10, Y=2, U=5. Expected: no mem_rd in the left slot, ll=1, uu=1.
- Right and bottom edges: X=635, R=10, Y=475, D=10. Expected: rr=1 with no read, dd=1.
- ent_valid=4'b0101. Expected: mem_rd only in cycles 1–3 and 7–9; flags for entities 1 and 3 are 0; done still in cycle 14.
- frame_start pulsed again in cycle 5. Expected: ignored. A pulse in cycle 14 starts a new scan whose done arrives in cycle 28.
- reset asserted in cycle 6 of a scan. Expected: busy=0 and all flags 0 from cycle 7, and no done pulse.

Source files
------------

// File: rtl/terrain_pkg.sv
// Shared constants and types for the terrain collision probe scheduler.
package terrain_pkg;
  localparam int COLS      = 640;
  localparam int ROWS      = 480;
  localparam int ROW_BITS  = 512;
  localparam int POS_W     = 10;
  localparam int CALC_W    = POS_W + 1;
  localparam int ROW_IDX_W = $clog2(ROW_BITS);

  typedef enum logic [1:0] {
    SLOT_CENTER = 2'd0,
    SLOT_LEFT   = 2'd1,
    SLOT_RIGHT  = 2'd2
  } slot_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/probe_addr_gen.sv
// Combinational column/row generator for one probe slot of one entity.
module probe_addr_gen
  import terrain_pkg::*;
(
  input  logic [POS_W-1:0]     x,
  input  logic [POS_W-1:0]     y,
  input  logic [POS_W-1:0]     d,
  input  logic [POS_W-1:0]     u,
  input  logic [POS_W-1:0]     l,
  input  logic [POS_W-1:0]     r,
  input  slot_e                slot,
  output logic [POS_W-1:0]     col,
  output logic                 col_ok,
  output logic [ROW_IDX_W-1:0] row_a,
  output logic                 row_a_ok,
  output logic [ROW_IDX_W-1:0] row_b,
  output logic                 row_b_ok
);
  logic [CALC_W-1:0] x_s, y_s, col_s, row_a_s, row_b_s;

  assign x_s = {1'b0, x};
  assign y_s = {1'b0, y};

  // Underflow wraps above 1023 at this width, so one upper-bound compare catches both cases.
  always_comb begin
    col_s   = x_s;
    row_a_s = y_s;
    row_b_s = y_s;
    case (slot)
      SLOT_CENTER: begin
        row_a_s = y_s + {1'b0, d};
        row_b_s = y_s - {1'b0, u};
      end
      SLOT_LEFT:  col_s = x_s - {1'b0, l};
      SLOT_RIGHT: col_s = x_s + {1'b0, r};
      default:    col_s = {CALC_W{1'b1}};
    endcase
  end

  assign col      = col_s[POS_W-1:0];
  assign col_ok   = col_s < CALC_W'(COLS);
  assign row_a    = row_a_s[ROW_IDX_W-1:0];
  assign row_a_ok = row_a_s < CALC_W'(ROWS);
  assign row_b    = row_b_s[ROW_IDX_W-1:0];
  assign row_b_ok = row_b_s < CALC_W'(ROWS);
endmodule

// File: rtl/terrain_probe_sched.sv
// Per-frame terrain probe scheduler: three column reads per entity, flags published atomically.
module terrain_probe_sched
  import terrain_pkg::*;
#(
  parameter int N_ENT = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        frame_start,
  input  logic [N_ENT-1:0]            ent_valid,
  input  logic [N_ENT-1:0][POS_W-1:0] ent_x,
  input  logic [N_ENT-1:0][POS_W-1:0] ent_y,
  input  logic [N_ENT-1:0][POS_W-1:0] ent_d,
  input  logic [N_ENT-1:0][POS_W-1:0] ent_u,
  input  logic [N_ENT-1:0][POS_W-1:0] ent_l,
  input  logic [N_ENT-1:0][POS_W-1:0] ent_r,
  output logic                        mem_rd,
  output logic [POS_W-1:0]            mem_addr,
  input  logic [ROW_BITS-1:0]         mem_data,
  output logic [N_ENT-1:0]            dd,
  output logic [N_ENT-1:0]            uu,
  output logic [N_ENT-1:0]            ll,
  output logic [N_ENT-1:0]            rr,
  output logic                        busy,
  output logic                        done
);
  localparam int CW = $clog2(N_ENT + 1);
  localparam int IW = (N_ENT > 1) ? $clog2(N_ENT) : 1;
  localparam logic [CW-1:0] ENT_END = CW'(N_ENT);

  state_e state_r, state_nxt_s;
  logic [CW-1:0] ent_cnt_r, ent_cnt_nxt_s;
  slot_e typ_r, typ_nxt_s;
  logic [IW-1:0] ent_idx_s;

  logic [N_ENT-1:0] valid_r;
  logic [N_ENT-1:0][POS_W-1:0] x_r, y_r, d_r, u_r, l_r, r_r;

  logic src_valid_s;
  logic [POS_W-1:0] src_x_s, src_y_s, src_d_s, src_u_s, src_l_s, src_r_s;
  slot_e src_slot_s;
  logic [IW-1:0] src_ent_s;

  logic [POS_W-1:0] col_s;
  logic [ROW_IDX_W-1:0] row_a_s, row_b_s;
  logic col_ok_s, row_a_ok_s, row_b_ok_s;
  logic start_s, issue_s, rd_s;

  logic iss_act_r, iss_zero_r, iss_fa_r, iss_fb_r;
  logic ret_act_r, ret_zero_r, ret_fa_r, ret_fb_r;
  logic [IW-1:0] iss_ent_r, ret_ent_r;
  slot_e iss_slot_r, ret_slot_r;
  logic [ROW_IDX_W-1:0] iss_row_a_r, iss_row_b_r, ret_row_a_r, ret_row_b_r;

  logic bit_a_s, bit_b_s;
  logic [N_ENT-1:0] sh_d_r, sh_u_r, sh_l_r, sh_r_r;
  logic [N_ENT-1:0] sh_d_nxt_s, sh_u_nxt_s, sh_l_nxt_s, sh_r_nxt_s;

  // A pulse in the DONE cycle is accepted since the FSM is leaving anyway.
  assign start_s   = frame_start && (state_r == ST_IDLE || state_r == ST_DONE);
  assign issue_s   = start_s || (state_r == ST_SCAN && ent_cnt_r != ENT_END);
  assign ent_idx_s = ent_cnt_r[IW-1:0];
  assign rd_s      = issue_s && src_valid_s && col_ok_s;

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  state_nxt_s = frame_start ? ST_SCAN : ST_IDLE;
      ST_SCAN:  state_nxt_s = (ent_cnt_r == ENT_END) ? ST_DRAIN : ST_SCAN;
      ST_DRAIN: state_nxt_s = ST_DONE;
      ST_DONE:  state_nxt_s = frame_start ? ST_SCAN : ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Slot counter: entity index plus probe type of the next slot to issue.
  always_comb begin
    ent_cnt_nxt_s = ent_cnt_r;
    typ_nxt_s     = typ_r;
    if (start_s) begin
      ent_cnt_nxt_s = {CW{1'b0}};
      typ_nxt_s     = SLOT_LEFT;
    end else if (issue_s) begin
      case (typ_r)
        SLOT_CENTER: typ_nxt_s = SLOT_LEFT;
        SLOT_LEFT:   typ_nxt_s = SLOT_RIGHT;
        SLOT_RIGHT: begin
          typ_nxt_s     = SLOT_CENTER;
          ent_cnt_nxt_s = ent_cnt_r + CW'(1);
        end
        default:     typ_nxt_s = SLOT_CENTER;
      endcase
    end else begin
      typ_nxt_s = typ_r;
    end
  end

  // Slot 0 is issued from the live inputs on the start edge so mem_rd stays registered.
  always_comb begin
    src_valid_s = ent_valid[0];
    src_x_s     = ent_x[0];
    src_y_s     = ent_y[0];
    src_d_s     = ent_d[0];
    src_u_s     = ent_u[0];
    src_l_s     = ent_l[0];
    src_r_s     = ent_r[0];
    src_slot_s  = SLOT_CENTER;
    src_ent_s   = {IW{1'b0}};
    if (state_r == ST_SCAN) begin
      src_valid_s = valid_r[ent_idx_s];
      src_x_s     = x_r[ent_idx_s];
      src_y_s     = y_r[ent_idx_s];
      src_d_s     = d_r[ent_idx_s];
      src_u_s     = u_r[ent_idx_s];
      src_l_s     = l_r[ent_idx_s];
      src_r_s     = r_r[ent_idx_s];
      src_slot_s  = typ_r;
      src_ent_s   = ent_idx_s;
    end else begin
      src_slot_s  = SLOT_CENTER;
    end
  end

  probe_addr_gen u_addr_gen (
    .x        (src_x_s),
    .y        (src_y_s),
    .d        (src_d_s),
    .u        (src_u_s),
    .l        (src_l_s),
    .r        (src_r_s),
    .slot     (src_slot_s),
    .col      (col_s),
    .col_ok   (col_ok_s),
    .row_a    (row_a_s),
    .row_a_ok (row_a_ok_s),
    .row_b    (row_b_s),
    .row_b_ok (row_b_ok_s)
  );

  // FSM, counters and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      ent_cnt_r <= {CW{1'b0}};
      typ_r     <= SLOT_CENTER;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      ent_cnt_r <= ent_cnt_nxt_s;
      typ_r     <= typ_nxt_s;
      busy      <= (state_nxt_s == ST_SCAN) || (state_nxt_s == ST_DRAIN);
      done      <= (state_nxt_s == ST_DONE);
    end
  end

  // Entity snapshot taken at scan start.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= {N_ENT{1'b0}};
      x_r <= '{default: {POS_W{1'b0}}};
      y_r <= '{default: {POS_W{1'b0}}};
      d_r <= '{default: {POS_W{1'b0}}};
      u_r <= '{default: {POS_W{1'b0}}};
      l_r <= '{default: {POS_W{1'b0}}};
      r_r <= '{default: {POS_W{1'b0}}};
    end else if (start_s) begin
      valid_r <= ent_valid;
      x_r <= ent_x;
      y_r <= ent_y;
      d_r <= ent_d;
      u_r <= ent_u;
      l_r <= ent_l;
      r_r <= ent_r;
    end
  end

  // Read strobe/address plus the slot tag that follows the read word back.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rd      <= 1'b0;
      mem_addr    <= {POS_W{1'b0}};
      iss_act_r   <= 1'b0;
      iss_ent_r   <= {IW{1'b0}};
      iss_slot_r  <= SLOT_CENTER;
      iss_zero_r  <= 1'b0;
      iss_fa_r    <= 1'b0;
      iss_fb_r    <= 1'b0;
      iss_row_a_r <= {ROW_IDX_W{1'b0}};
      iss_row_b_r <= {ROW_IDX_W{1'b0}};
      ret_act_r   <= 1'b0;
      ret_ent_r   <= {IW{1'b0}};
      ret_slot_r  <= SLOT_CENTER;
      ret_zero_r  <= 1'b0;
      ret_fa_r    <= 1'b0;
      ret_fb_r    <= 1'b0;
      ret_row_a_r <= {ROW_IDX_W{1'b0}};
      ret_row_b_r <= {ROW_IDX_W{1'b0}};
    end else begin
      mem_rd <= rd_s;
      if (rd_s) mem_addr <= col_s;
      iss_act_r   <= issue_s;
      iss_ent_r   <= src_ent_s;
      iss_slot_r  <= src_slot_s;
      iss_zero_r  <= ~src_valid_s;
      iss_fa_r    <= ~col_ok_s | ~row_a_ok_s;
      iss_fb_r    <= ~col_ok_s | ~row_b_ok_s;
      iss_row_a_r <= row_a_s;
      iss_row_b_r <= row_b_s;
      ret_act_r   <= iss_act_r;
      ret_ent_r   <= iss_ent_r;
      ret_slot_r  <= iss_slot_r;
      ret_zero_r  <= iss_zero_r;
      ret_fa_r    <= iss_fa_r;
      ret_fb_r    <= iss_fb_r;
      ret_row_a_r <= iss_row_a_r;
      ret_row_b_r <= iss_row_b_r;
    end
  end

  // Invalid entities read as 0; off-screen columns or rows read as solid.
  assign bit_a_s = ret_zero_r ? 1'b0 : (ret_fa_r ? 1'b1 : mem_data[ret_row_a_r]);
  assign bit_b_s = ret_zero_r ? 1'b0 : (ret_fb_r ? 1'b1 : mem_data[ret_row_b_r]);

  // Merge the returning slot into the shadow flags.
  always_comb begin
    sh_d_nxt_s = sh_d_r;
    sh_u_nxt_s = sh_u_r;
    sh_l_nxt_s = sh_l_r;
    sh_r_nxt_s = sh_r_r;
    if (ret_act_r) begin
      case (ret_slot_r)
        SLOT_CENTER: begin
          sh_d_nxt_s[ret_ent_r] = bit_a_s;
          sh_u_nxt_s[ret_ent_r] = bit_b_s;
        end
        SLOT_LEFT:  sh_l_nxt_s[ret_ent_r] = bit_a_s;
        SLOT_RIGHT: sh_r_nxt_s[ret_ent_r] = bit_a_s;
        default:    sh_d_nxt_s = sh_d_r;
      endcase
    end else begin
      sh_d_nxt_s = sh_d_r;
    end
  end

  // Shadow registers; published flags load only on the edge into DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_d_r <= {N_ENT{1'b0}};
      sh_u_r <= {N_ENT{1'b0}};
      sh_l_r <= {N_ENT{1'b0}};
      sh_r_r <= {N_ENT{1'b0}};
      dd     <= {N_ENT{1'b0}};
      uu     <= {N_ENT{1'b0}};
      ll     <= {N_ENT{1'b0}};
      rr     <= {N_ENT{1'b0}};
    end else begin
      sh_d_r <= sh_d_nxt_s;
      sh_u_r <= sh_u_nxt_s;
      sh_l_r <= sh_l_nxt_s;
      sh_r_r <= sh_r_nxt_s;
      if (state_r == ST_DRAIN) begin
        dd <= sh_d_nxt_s;
        uu <= sh_u_nxt_s;
        ll <= sh_l_nxt_s;
        rr <= sh_r_nxt_s;
      end
    end
  end
endmodule

// File: tb/tb_terrain_probe_sched.sv
// Directed and randomized bench for terrain_probe_sched against a probe-level reference model.
module tb_terrain_probe_sched;
  import terrain_pkg::*;
  localparam int N   = 4;
  localparam int LAT = 3 * N + 2;

  logic clk = 1'b0;
  logic reset, frame_start;
  logic [N-1:0] ent_valid;
  logic [N-1:0][9:0] ent_x, ent_y, ent_d, ent_u, ent_l, ent_r;
  logic mem_rd;
  logic [9:0] mem_addr;
  logic [ROW_BITS-1:0] mem_data = '0;
  logic [N-1:0] dd, uu, ll, rr;
  logic busy, done;

  logic [ROW_BITS-1:0] colmem [COLS];
  int m_x [N], m_y [N], m_d [N], m_u [N], m_l [N], m_r [N];
  bit m_v [N];
  logic [N-1:0] e_dd = '0, e_uu = '0, e_ll = '0, e_rr = '0;
  int last_addr = 0;
  int checks = 0, errors = 0;

  terrain_probe_sched #(.N_ENT(N)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .ent_valid(ent_valid),
    .ent_x(ent_x), .ent_y(ent_y), .ent_d(ent_d), .ent_u(ent_u), .ent_l(ent_l), .ent_r(ent_r),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .dd(dd), .uu(uu), .ll(ll), .rr(rr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Single-port column RAM: word appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_data <= colmem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Screen outside the bitmap is solid.
  function automatic bit probe_bit(input int c, input int row);
    if (c < 0 || c >= COLS || row < 0 || row >= ROWS) return 1'b1;
    return colmem[c][row];
  endfunction

  task automatic set_ent(input int i, input bit v, input int x, input int y,
                         input int d, input int u, input int l, input int r);
    m_v[i] = v; m_x[i] = x; m_y[i] = y; m_d[i] = d; m_u[i] = u; m_l[i] = l; m_r[i] = r;
  endtask

  task automatic rand_ents(input logic [N-1:0] vmask);
    for (int i = 0; i < N; i++) begin
      m_v[i] = vmask[i];
      m_x[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(600, 1023) : $urandom_range(0, 639);
      m_y[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(440, 1023) : $urandom_range(0, 479);
      m_d[i] = $urandom_range(0, 63);
      m_u[i] = $urandom_range(0, 63);
      m_l[i] = $urandom_range(0, 63);
      m_r[i] = $urandom_range(0, 63);
    end
  endtask

  task automatic fill_cols();
    for (int c = 0; c < COLS; c++)
      for (int w = 0; w < ROW_BITS / 32; w++) colmem[c][w*32 +: 32] = $urandom;
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      ent_valid[i] = m_v[i];
      ent_x[i] = 10'(m_x[i]); ent_y[i] = 10'(m_y[i]);
      ent_d[i] = 10'(m_d[i]); ent_u[i] = 10'(m_u[i]);
      ent_l[i] = 10'(m_l[i]); ent_r[i] = 10'(m_r[i]);
    end
  endtask

  task automatic scramble();
    ent_valid = N'($urandom);
    for (int i = 0; i < N; i++) begin
      ent_x[i] = 10'($urandom); ent_y[i] = 10'($urandom);
      ent_d[i] = 10'($urandom); ent_u[i] = 10'($urandom);
      ent_l[i] = 10'($urandom); ent_r[i] = 10'($urandom);
    end
  endtask

  task automatic chk_flags(input string pfx);
    chk({pfx, "_dd"}, 32'(dd), 32'(e_dd));
    chk({pfx, "_uu"}, 32'(uu), 32'(e_uu));
    chk({pfx, "_ll"}, 32'(ll), 32'(e_ll));
    chk({pfx, "_rr"}, 32'(rr), 32'(e_rr));
  endtask

  // One full scan; extra = cycle of an additional frame_start pulse, pre = already started.
  task automatic run_scan(input int extra, input bit pre);
    logic [N-1:0] n_dd, n_uu, n_ll, n_rr;
    bit rd_exp [LAT+1];
    int addr_exp [LAT+1];
    int cols [3];
    apply();
    for (int k = 0; k <= LAT; k++) begin rd_exp[k] = 1'b0; addr_exp[k] = 0; end
    for (int i = 0; i < N; i++) begin
      n_dd[i] = m_v[i] ? probe_bit(m_x[i], m_y[i] + m_d[i]) : 1'b0;
      n_uu[i] = m_v[i] ? probe_bit(m_x[i], m_y[i] - m_u[i]) : 1'b0;
      n_ll[i] = m_v[i] ? probe_bit(m_x[i] - m_l[i], m_y[i]) : 1'b0;
      n_rr[i] = m_v[i] ? probe_bit(m_x[i] + m_r[i], m_y[i]) : 1'b0;
      cols[0] = m_x[i]; cols[1] = m_x[i] - m_l[i]; cols[2] = m_x[i] + m_r[i];
      for (int j = 0; j < 3; j++) begin
        rd_exp[3*i+j+1]   = m_v[i] && cols[j] >= 0 && cols[j] < COLS;
        addr_exp[3*i+j+1] = cols[j];
      end
    end
    if (!pre) begin @(negedge clk); frame_start = 1'b1; end
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      frame_start = (c == extra);
      if (c == 1) scramble();
      chk("busy", 32'(busy), 32'(c <= LAT - 1));
      chk("done", 32'(done), 32'(c == LAT));
      chk("mem_rd", 32'(mem_rd), 32'(rd_exp[c]));
      if (rd_exp[c]) last_addr = addr_exp[c];
      chk("mem_addr", 32'(mem_addr), 32'(last_addr));
      if (c == LAT) begin e_dd = n_dd; e_uu = n_uu; e_ll = n_ll; e_rr = n_rr; end
      chk_flags("flags");
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_rd", 32'(mem_rd), 32'd0);
      chk("idle_addr", 32'(mem_addr), 32'(last_addr));
      chk_flags("idle");
    end
  endtask

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    for (int i = 0; i < N; i++) set_ent(i, 1'b0, 0, 0, 0, 0, 0, 0);
    apply();
    for (int c = 0; c < COLS; c++) colmem[c] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd", 32'(mem_rd), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk_flags("rst");
    reset = 1'b0;
    idle(2);

    // Single entity with hand-placed terrain bits.
    set_ent(0, 1'b1, 100, 200, 10, 10, 10, 10);
    colmem[100][210] = 1'b1;
    colmem[90][200]  = 1'b1;
    run_scan(0, 1'b0);
    chk("t1_flags", 32'({dd[0], uu[0], ll[0], rr[0]}), 32'b1010);
    idle(2);

    // Left and top edges.
    set_ent(0, 1'b1, 5, 2, 0, 5, 10, 0);
    set_ent(1, 1'b1, 300, 100, 3, 4, 5, 6);
    run_scan(0, 1'b0);
    chk("t2_ll_uu", 32'({ll[0], uu[0]}), 32'b11);
    idle(1);

    // Right and bottom edges.
    set_ent(0, 1'b1, 635, 475, 10, 0, 0, 10);
    run_scan(0, 1'b0);
    chk("t3_rr_dd", 32'({rr[0], dd[0]}), 32'b11);
    idle(1);

    // Reset during a scan aborts it and clears published flags.
    rand_ents(4'b1111);
    apply();
    @(negedge clk);
    frame_start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      frame_start = 1'b0;
      if (c == 6) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    e_dd = '0; e_uu = '0; e_ll = '0; e_rr = '0;
    last_addr = 0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rd", 32'(mem_rd), 32'd0);
    chk("abort_addr", 32'(mem_addr), 32'd0);
    chk_flags("abort");
    idle(LAT + 2);

    // Partial validity.
    fill_cols();
    rand_ents(4'b0101);
    run_scan(0, 1'b0);
    chk("t4_invalid", 32'({dd[1], uu[1], ll[1], rr[1], dd[3], uu[3], ll[3], rr[3]}), 32'd0);
    idle(1);

    // Pulse mid-scan is dropped, not queued.
    rand_ents(4'b1111);
    run_scan(5, 1'b0);
    idle(3);

    // Pulse in the done cycle starts the next scan immediately.
    rand_ents(4'b1111);
    run_scan(LAT, 1'b0);
    rand_ents(4'b1011);
    run_scan(0, 1'b1);
    idle(2);

    for (int it = 0; it < 6; it++) begin
      if (it % 2 == 0) fill_cols();
      rand_ents(N'($urandom));
      run_scan(0, 1'b0);
      idle(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
